// File: rtl/bnn_pkg.sv
// Shared BNN accelerator definitions.
// State encoding, layer geometry defaults and datapath width.
package bnn_pkg;

  localparam int DW       = 32;
  localparam int NW_D     = 25;
  localparam int NPIX0_D  = 784;
  localparam int NPIX1_D  = 144;
  localparam int NOUT0_D  = 576;
  localparam int NOUT1_D  = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_RUN,
    S_DRAIN,
    S_NEXT,
    S_FIN
  } state_e;

endpackage

// File: rtl/wt_fetch.sv
// Weight ROM address sequencer for one output channel.
// Enables trail their address by one cycle to match ROM latency.
module wt_fetch
  import bnn_pkg::*;
#(
  parameter int NW = NW_D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       active_i,
  input  logic [3:0] ch_i,
  input  logic       wt_rdata_i,
  output logic [9:0] wt_raddr_o,
  output logic       wen_o,
  output logic       wbit_o,
  output logic       last_o
);

  localparam int KW = $clog2(NW + 1);

  logic [KW-1:0] k_q, k_d;
  logic          en_q, last_q;
  logic          issue;

  assign issue  = active_i && (k_q < KW'(NW));
  assign wen_o  = en_q;
  assign wbit_o = en_q & wt_rdata_i;
  assign last_o = last_q;

  // Address for bit k of channel ch while a fetch is in progress.
  always_comb begin
    wt_raddr_o = '0;
    k_d        = '0;
    if (active_i) begin
      k_d = issue ? k_q + KW'(1) : k_q;
    end
    if (issue) begin
      wt_raddr_o = 10'(int'(ch_i) * NW + int'(k_q));
    end
  end

  // Bit counter and one-cycle delayed enable/last flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q    <= '0;
      en_q   <= 1'b0;
      last_q <= 1'b0;
    end else begin
      k_q    <= k_d;
      en_q   <= issue;
      last_q <= issue && (k_q == KW'(NW - 1));
    end
  end

endmodule

// File: rtl/conv_sched.sv
// Per-channel scheduler feeding the conv_mix engine.
// Loads weights, streams pixels, drains results, loops channels.
module conv_sched
  import bnn_pkg::*;
#(
  parameter int NW    = NW_D,
  parameter int NPIX0 = NPIX0_D,
  parameter int NPIX1 = NPIX1_D,
  parameter int NOUT0 = NOUT0_D,
  parameter int NOUT1 = NOUT1_D
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic                 job_layer,
  input  logic [3:0]           job_nch,
  output logic [9:0]           wt_raddr,
  input  logic                 wt_rdata,
  input  logic                 px_valid,
  output logic                 px_ready,
  input  logic signed [DW-1:0] px_data,
  output logic                 cm_start,
  output logic                 cm_weight_en,
  output logic                 cm_weight,
  output logic [DW-1:0]        cm_din,
  output logic                 cm_state,
  input  logic                 cm_ovalid,
  input  logic                 cm_done,
  input  logic [DW-1:0]        cm_dout,
  output logic                 res_valid,
  output logic [DW-1:0]        res_data,
  output logic [3:0]           res_ch,
  output logic [9:0]           res_idx,
  output logic                 busy,
  output logic                 job_done,
  output logic                 err_underrun,
  output logic                 err_count
);

  state_e        state_q, state_d;
  logic          layer_q, layer_d;
  logic [3:0]    nch_q, nch_d;
  logic [3:0]    ch_q, ch_d;
  logic [9:0]    pix_q, pix_d;
  logic [9:0]    ocnt_q, ocnt_d;
  logic          eu_q, eu_d;
  logic          ec_q, ec_d;
  logic          rv_q;
  logic [DW-1:0] rd_q;
  logic [3:0]    rc_q;
  logic [9:0]    ri_q;
  logic          rdy;
  logic          load_act;
  logic          wlast;
  logic [9:0]    npix, nout;

  assign npix = layer_q ? 10'(NPIX1) : 10'(NPIX0);
  assign nout = layer_q ? 10'(NOUT1) : 10'(NOUT0);

  assign load_act     = (state_q == S_LOAD_W);
  assign job_ready    = rdy & ~rst;
  assign busy         = (state_q != S_IDLE);
  assign cm_state     = layer_q;
  assign err_underrun = eu_q;
  assign err_count    = ec_q;
  assign res_valid    = rv_q;
  assign res_data     = rd_q;
  assign res_ch       = rc_q;
  assign res_idx      = ri_q;

  wt_fetch #(.NW(NW)) u_wt_fetch (
    .clk        (clk),
    .rst        (rst),
    .active_i   (load_act),
    .ch_i       (ch_q),
    .wt_rdata_i (wt_rdata),
    .wt_raddr_o (wt_raddr),
    .wen_o      (cm_weight_en),
    .wbit_o     (cm_weight),
    .last_o     (wlast)
  );

  // Next state, job bookkeeping and per-state outputs.
  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    nch_d    = nch_q;
    ch_d     = ch_q;
    pix_d    = pix_q;
    ocnt_d   = ocnt_q + (cm_ovalid ? 10'd1 : 10'd0);
    eu_d     = eu_q;
    ec_d     = ec_q;
    rdy      = 1'b0;
    cm_start = 1'b0;
    px_ready = 1'b0;
    cm_din   = '0;
    job_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        rdy = 1'b1;
        if (job_valid) begin
          layer_d = job_layer;
          nch_d   = job_nch;
          ch_d    = '0;
          eu_d    = 1'b0;
          ec_d    = 1'b0;
          ocnt_d  = '0;
          state_d = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        pix_d = '0;
        if (wlast) state_d = S_RUN;
      end
      S_RUN: begin
        cm_start = 1'b1;
        px_ready = 1'b1;
        if (px_valid) cm_din = px_data;
        else          eu_d   = 1'b1;
        if (pix_q == npix - 10'd1) begin
          pix_d   = '0;
          state_d = S_DRAIN;
        end else begin
          pix_d = pix_q + 10'd1;
        end
      end
      S_DRAIN: begin
        if (cm_done) begin
          if (ocnt_d != nout) ec_d = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (ch_q == nch_q) begin
          state_d = S_FIN;
        end else begin
          ch_d    = ch_q + 4'd1;
          ocnt_d  = '0;
          state_d = S_LOAD_W;
        end
      end
      S_FIN: begin
        job_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      layer_q <= 1'b0;
      nch_q   <= '0;
      ch_q    <= '0;
      pix_q   <= '0;
      ocnt_q  <= '0;
      eu_q    <= 1'b0;
      ec_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      nch_q   <= nch_d;
      ch_q    <= ch_d;
      pix_q   <= pix_d;
      ocnt_q  <= ocnt_d;
      eu_q    <= eu_d;
      ec_q    <= ec_d;
    end
  end

  // Result register: one conv output per cycle, no backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv_q <= 1'b0;
      rd_q <= '0;
      rc_q <= '0;
      ri_q <= '0;
    end else begin
      rv_q <= cm_ovalid;
      if (cm_ovalid) begin
        rd_q <= cm_dout;
        rc_q <= ch_q;
        ri_q <= ocnt_q;
      end
    end
  end

endmodule

// File: tb/tb_conv_sched.sv
// Randomized bench for conv_sched with a behavioural conv engine,
// weight ROM and pixel source plus a result scoreboard.
module tb_conv_sched;
  import bnn_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        job_valid, job_ready, job_layer;
  logic [3:0]  job_nch;
  logic [9:0]  wt_raddr;
  logic        wt_rdata;
  logic        px_valid, px_ready;
  logic [31:0] px_data;
  logic        cm_start, cm_weight_en, cm_weight, cm_state;
  logic [31:0] cm_din;
  logic        cm_ovalid, cm_done;
  logic [31:0] cm_dout;
  logic        res_valid;
  logic [31:0] res_data;
  logic [3:0]  res_ch;
  logic [9:0]  res_idx;
  logic        busy, job_done, err_underrun, err_count;

  always #5 clk = ~clk;

  conv_sched dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_layer(job_layer), .job_nch(job_nch),
    .wt_raddr(wt_raddr), .wt_rdata(wt_rdata),
    .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
    .cm_start(cm_start), .cm_weight_en(cm_weight_en),
    .cm_weight(cm_weight), .cm_din(cm_din), .cm_state(cm_state),
    .cm_ovalid(cm_ovalid), .cm_done(cm_done), .cm_dout(cm_dout),
    .res_valid(res_valid), .res_data(res_data),
    .res_ch(res_ch), .res_idx(res_idx),
    .busy(busy), .job_done(job_done),
    .err_underrun(err_underrun), .err_count(err_count)
  );

  typedef struct {
    logic [31:0] d;
    int          ch;
    int          idx;
  } res_t;

  res_t rq[$];
  bit   rom[1024];
  int   n_tests, n_fail;
  int   n_en[16], n_start[16], n_res[16];
  int   n_loads, n_start_tot, n_jd, n_acc, n_done_m;
  bit   exp_under, prev_en;
  int   prev_addr;
  int   emit_n, cur_layer;
  bit   spur_en, gap_en;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_job();
    n_loads = 0; n_start_tot = 0; n_jd = 0; n_acc = 0;
    n_done_m = 0; exp_under = 0;
    for (int i = 0; i < 16; i++) begin
      n_en[i] = 0; n_start[i] = 0; n_res[i] = 0;
    end
    rq.delete();
  endtask

  // Monitor and scoreboard, sampled on the falling edge.
  initial begin
    forever begin
      int   c, ix;
      res_t e;
      @(negedge clk);
      if (!rst) begin
        if (cm_weight_en && !prev_en) n_loads++;
        c = (n_loads > 0) ? n_loads - 1 : 0;
        if (c > 15) c = 15;
        if (cm_weight_en) begin
          ix = (c * NW_D + n_en[c]) % 1024;
          chk("waddr", 32'(prev_addr), 32'(c * NW_D + n_en[c]));
          chk("wbit", 32'(cm_weight), 32'(rom[ix]));
          n_en[c]++;
        end
        if (cm_start) begin
          if (n_start[c] == 0) chk("run_gap", 32'(prev_en), 32'd1);
          chk("din", cm_din, px_valid ? px_data : 32'd0);
          chk("px_ready", 32'(px_ready), 32'd1);
          chk("cm_state", 32'(cm_state), 32'(cur_layer));
          if (!px_valid) exp_under = 1;
          n_start[c]++;
          n_start_tot++;
        end
        if (res_valid) begin
          if (rq.size() == 0) begin
            chk("res_extra", 32'd1, 32'd0);
          end else begin
            e = rq.pop_front();
            chk("rdata", res_data, e.d);
            chk("rch", 32'(res_ch), 32'(e.ch));
            chk("ridx", 32'(res_idx), 32'(e.idx));
            if (e.ch >= 0 && e.ch < 16) n_res[e.ch]++;
          end
        end
        if (job_done) n_jd++;
        if (job_valid && job_ready) n_acc++;
        prev_en   = cm_weight_en;
        prev_addr = int'(wt_raddr);
      end else begin
        prev_en   = 0;
        prev_addr = 0;
      end
    end
  end

  // Behavioural conv engine: absorb pixels, then emit emit_n outputs
  // and a done pulse; optionally a stray done while pixels stream.
  initial begin
    int ph, cnt, e;
    ph = 0; cnt = 0; e = 0;
    cm_ovalid = 0; cm_done = 0; cm_dout = 0;
    forever begin
      @(negedge clk);
      cm_ovalid = 0;
      cm_done   = 0;
      if (rst) begin
        ph = 0;
      end else begin
        if (ph == 0 && cm_start) begin
          ph = 1; cnt = 1;
        end else if (ph == 1) begin
          if (cm_start) begin
            cnt++;
            if (spur_en && cnt == 50) cm_done = 1;
          end else begin
            ph = 2; e = 0;
          end
        end
        if (ph == 2) begin
          if (e < emit_n) begin
            cm_ovalid = 1;
            cm_dout   = $urandom;
            rq.push_back('{cm_dout, n_done_m, e});
            e++;
          end else begin
            cm_done = 1;
            n_done_m++;
            ph = 0;
          end
        end
      end
    end
  end

  // Weight ROM (one-cycle latency) and pixel source.
  initial begin
    wt_rdata = 0; px_valid = 1; px_data = 0;
    forever begin
      @(posedge clk);
      #1;
      wt_rdata = rom[prev_addr % 1024];
      px_data  = $urandom;
      px_valid = !(gap_en && n_start_tot >= 40 && n_start_tot <= 42);
    end
  end

  task automatic run_job(input int layer, input int nch, input int emit,
                         input bit spur, input bit gap, input bit hold);
    int t, npix, nout;
    bit clr;
    npix = layer ? NPIX1_D : NPIX0_D;
    nout = layer ? NOUT1_D : NOUT0_D;
    @(posedge clk);
    #1;
    clear_job();
    emit_n = emit; spur_en = spur; gap_en = gap; cur_layer = layer;
    job_layer = layer[0]; job_nch = 4'(nch); job_valid = 1;
    t = 0; clr = 0;
    while (n_jd == 0 && t < 20000) begin
      @(posedge clk);
      #1;
      t++;
      if (n_acc > 0 && !clr) begin
        clr = 1;
        chk("clr_under", 32'(err_underrun), 32'd0);
        chk("clr_cnt", 32'(err_count), 32'd0);
        chk("busy_run", 32'(busy), 32'd1);
        if (!hold) job_valid = 0;
      end
    end
    job_valid = 0;
    chk("timeout", 32'(n_jd > 0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("job_done_cnt", 32'(n_jd), 32'd1);
    chk("accepts", 32'(n_acc), 32'd1);
    chk("loads", 32'(n_loads), 32'(nch + 1));
    chk("dones", 32'(n_done_m), 32'(nch + 1));
    for (int c = 0; c <= nch; c++) begin
      chk("n_wen", 32'(n_en[c]), 32'(NW_D));
      chk("n_start", 32'(n_start[c]), 32'(npix));
      chk("n_res", 32'(n_res[c]), 32'(emit));
    end
    chk("res_left", 32'(rq.size()), 32'd0);
    chk("err_under", 32'(err_underrun), 32'(exp_under));
    chk("err_cnt", 32'(err_count), 32'(emit != nout));
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'(job_ready), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    n_tests = 0; n_fail = 0;
    job_valid = 0; job_layer = 0; job_nch = 0;
    emit_n = 0; spur_en = 0; gap_en = 0; cur_layer = 0;
    prev_addr = 0; prev_en = 0;
    clear_job();
    foreach (rom[i]) rom[i] = 1'($urandom_range(0, 1));

    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(cm_start), 32'd0);
    chk("rst_res", 32'(res_valid), 32'd0);
    chk("rst_addr", 32'(wt_raddr), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rel_ready", 32'(job_ready), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);
    chk("rel_flags", {30'd0, err_underrun, err_count}, 32'd0);

    run_job(0, 0, NOUT0_D, 0, 0, 0);
    run_job(1, 2, NOUT1_D, 0, 0, 0);
    run_job(1, 0, NOUT1_D, 0, 1, 0);
    run_job(1, 1, NOUT1_D, 0, 0, 0);
    run_job(0, 0, NOUT0_D - 1, 0, 0, 0);
    run_job(1, 1, NOUT1_D, 1, 0, 1);

    // Reset in the middle of a layer-0 pixel stream.
    @(posedge clk);
    #1;
    clear_job();
    emit_n = NOUT0_D; spur_en = 0; gap_en = 0; cur_layer = 0;
    job_layer = 0; job_nch = 0; job_valid = 1;
    t = 0;
    while (n_start_tot < 300 && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
      if (n_acc > 0) job_valid = 0;
    end
    chk("mid_reach", 32'(n_start_tot), 32'd300);
    rst = 1;
    #2;
    chk("mid_start", 32'(cm_start), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_res", 32'(res_valid), 32'd0);
    chk("mid_pxr", 32'(px_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("mid_ready", 32'(job_ready), 32'd1);
    chk("mid_start2", 32'(cm_start), 32'd0);
    chk("mid_res2", 32'(res_valid), 32'd0);

    for (int i = 0; i < 4; i++) begin
      int nc;
      bit short;
      nc    = $urandom_range(0, 3);
      short = ($urandom_range(0, 3) == 0);
      run_job(1, nc, short ? NOUT1_D - 1 : NOUT1_D,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 SHALL have parameter NW, default 25, meaning weight bits per output channel (5x5 binary kernel).
REQ-002 SHALL have parameter NPIX0, default 784, meaning input pixels per channel for layer 0.
REQ-003 SHALL have parameter NPIX1, default 144, meaning input pixels per channel for layer 1.
REQ-004 SHALL have parameters NOUT0, default 576, and NOUT1, default 64, meaning expected conv outputs per channel for layers 0 and 1.
REQ-005 SHALL have ports clk (in, 1, sole clock) and rst (in, 1, asynchronous active-high reset).
REQ-006 SHALL have job ports job_valid (in, 1), job_ready (out, 1), job_layer (in, 1, conv state), job_nch (in, 4, output channel count minus 1).
REQ-007 SHALL have weight-ROM ports wt_raddr (out, 10, bit address = ch*NW+k) and wt_rdata (in, 1, valid one cycle after address).
REQ-008 SHALL have pixel ports px_valid (in, 1), px_ready (out, 1), px_data (in, 32, signed).
REQ-009 SHALL have conv_mix ports cm_start (out, 1), cm_weight_en (out, 1), cm_weight (out, 1), cm_din (out, 32), cm_state (out, 1), cm_ovalid (in, 1), cm_done (in, 1), cm_dout (in, 32).
REQ-010 SHALL have result ports res_valid (out, 1), res_data (out, 32), res_ch (out, 4), res_idx (out, 10).
REQ-011 SHALL have status ports busy (out, 1), job_done (out, 1, one-cycle pulse), err_underrun (out, 1, sticky), err_count (out, 1, sticky).

Function
REQ-012 SHALL implement FSM states IDLE, LOAD_W, RUN, DRAIN, NEXT, FIN.
REQ-013 SHALL assert job_ready only in IDLE; on job_valid&&job_ready it SHALL latch job_layer/job_nch, clear ch, clear both error flags, and enter LOAD_W.
REQ-014 LOAD_W SHALL drive wt_raddr = ch*NW+k for k=0..NW-1 on consecutive cycles, then present each wt_rdata as cm_weight with cm_weight_en=1 exactly one cycle after its address, i.e. NW enable cycles in total.
REQ-015 SHALL enter RUN the cycle after the last cm_weight_en.
REQ-016 RUN SHALL hold cm_start=1 and px_ready=1 for exactly NPIX(layer) cycles, with cm_din=px_data when px_valid=1, and cm_din=0 plus sticky err_underrun set when px_valid=0.
REQ-017 SHALL drive cm_state from the latched layer for the whole job.
REQ-018 DRAIN SHALL hold cm_start=0 and px_ready=0 until cm_done=1, then enter NEXT.
REQ-019 NEXT SHALL last one cycle: if ch==nch, enter FIN; otherwise increment ch and enter LOAD_W.
REQ-020 FIN SHALL pulse job_done for one cycle and return to IDLE.
REQ-021 SHALL register each cm_ovalid cycle to res_valid=1, res_data=cm_dout, res_ch=ch, res_idx=per-channel output count, with 1-cycle latency and no backpressure.
REQ-022 SHALL reset the output count on entering LOAD_W; if cm_done arrives with a count different from NOUT(layer), it SHALL set sticky err_count and still proceed.
REQ-023 SHALL drive busy=1 in every state except IDLE.
REQ-024 SHALL ignore cm_done outside DRAIN and job_valid outside IDLE.

Reset
REQ-025 SHALL, while rst=1 and asynchronously at any state, force the FSM to IDLE, all counters to 0, and every output to 0 except job_ready, which SHALL be 1 after reset release.

Structure
REQ-026 SHALL import the state encoding, NW/NPIX/NOUT defaults and the 32-bit data width from shared package bnn_pkg.
REQ-027 SHALL place weight address generation and the enable alignment in one sub-module, wt_fetch; everything else SHALL be flat.

Verification
REQ-028 Reset mid-RUN (layer 0, pixel 300): rst pulse -> next cycle state IDLE, cm_start=0, job_ready=1, res_valid=0.
REQ-029 Job layer=0, nch=0, continuous pixels, model conv returning 576 ovalid -> 25 weight enables, 784 cm_start cycles, 576 results idx 0..575, job_done once, no errors.
REQ-030 Job layer=1, nch=2 -> wt_raddr sequences 0..24, 25..49, 50..74; res_ch 0,1,2 with 64 results each; exactly 3 cm_done consumed.
REQ-031 px_valid dropped for 3 cycles in RUN -> err_underrun=1, RUN length still 144 cycles (layer 1), flag cleared on next job accept.
REQ-032 Model emits 575 outputs then cm_done (layer 0) -> err_count=1, FSM continues to FIN.
REQ-033 job_valid held high during busy, plus cm_done while in RUN -> no second job accepted and no early exit from RUN.
